// File: rtl/baseline_tracker.sv
// baseline_tracker: per-channel EMA baseline with pulse hold-off; optional macro BLR_CLAMP_EN clamps negative residuals to 0
module baseline_tracker #(
  parameter int DATA_W  = 14,
  parameter int NCH     = 4,
  parameter int K_SHIFT = 4,
  parameter int FRAC_W  = 8,
  parameter int HOLDOFF = 16,
  localparam int CH_W   = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] thresh,
  input  logic              bl_clear,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W:0]   out_data,
  output logic [DATA_W-1:0] out_baseline,
  output logic              out_hold
);
  localparam int AW = DATA_W + FRAC_W;
  typedef enum logic [1:0] {INIT, TRACK, HOLD} st_t;
  logic [AW-1:0] acc [NCH];
  st_t st [NCH];
  logic [7:0] cnt [NCH];
  logic ok, init, trk, hi, o_hold;
  st_t cs, n_st;
  logic [AW-1:0] ca, tgt, n_acc;
  logic [7:0] cc, n_cnt;
  logic [DATA_W-1:0] base, o_bl;
  logic signed [DATA_W:0] res, o_res;
  logic signed [AW:0] diff, upd;
  logic s1_v, s1_h;
  logic [CH_W-1:0] s1_ch;
  logic [DATA_W:0] s1_res;
  logic [DATA_W-1:0] s1_bl;
  always_comb begin
    ok = in_valid && (32'(in_ch) < NCH);
    cs = bl_clear ? INIT : st[in_ch];
    ca = acc[in_ch];
    cc = cnt[in_ch];
    base = ca[AW-1:FRAC_W];
    res = $signed({1'b0, in_data}) - $signed({1'b0, base});
    hi = res > $signed({1'b0, thresh});
    tgt = {in_data, {FRAC_W{1'b0}}};
    // the step lies between acc and tgt, so the sum cannot leave [0, tgt_max]
    diff = $signed({1'b0, tgt}) - $signed({1'b0, ca});
    upd = $signed({1'b0, ca}) + (diff >>> K_SHIFT);
    init = cs == INIT;
    trk = cs == TRACK;
    n_acc = init ? tgt : (trk && !hi) ? upd[AW-1:0] : ca;
    n_cnt = init ? cc : hi ? 8'(HOLDOFF) : trk ? cc : cc - 8'd1;
    n_st = init ? TRACK : hi ? HOLD : trk ? TRACK : (cc <= 8'd1) ? TRACK : HOLD;
    o_hold = !init && (hi || !trk);
    o_res = init ? '0 : res;
    o_bl = init ? in_data : base;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        st[i] <= INIT;
        cnt[i] <= '0;
      end
      s1_v <= 1'b0;
      s1_ch <= '0;
      s1_res <= '0;
      s1_bl <= '0;
      s1_h <= 1'b0;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
      out_baseline <= '0;
      out_hold <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (bl_clear) st[i] <= INIT;
      if (ok) begin
        st[in_ch] <= n_st;
        acc[in_ch] <= n_acc;
        cnt[in_ch] <= n_cnt;
      end
      s1_v <= ok;
      s1_ch <= in_ch;
      s1_res <= o_res;
      s1_bl <= o_bl;
      s1_h <= o_hold;
      out_valid <= s1_v;
      out_ch <= s1_ch;
`ifdef BLR_CLAMP_EN
      out_data <= s1_res[DATA_W] ? '0 : s1_res;
`else
      out_data <= s1_res;
`endif
      out_baseline <= s1_bl;
      out_hold <= s1_h;
    end
  end
endmodule

// File: tb/tb_baseline_tracker.sv
// tb_baseline_tracker: directed vector table plus hand sequences for hold-off, reset and channel filtering
module tb_baseline_tracker;
  logic clk = 0, rst_n, in_valid, bl_clear;
  logic [1:0] in_ch;
  logic [13:0] in_data, thresh;
  logic out_valid, out_hold;
  logic [1:0] out_ch;
  logic [14:0] out_data;
  logic [13:0] out_baseline;
  logic v5, ov5, oh5;
  logic [2:0] ch5, och5;
  logic [14:0] od5;
  logic [13:0] ob5;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  baseline_tracker #(.DATA_W(14), .NCH(4), .K_SHIFT(4), .FRAC_W(8), .HOLDOFF(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .thresh(thresh), .bl_clear(bl_clear), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data), .out_baseline(out_baseline), .out_hold(out_hold));
  baseline_tracker #(.DATA_W(14), .NCH(5), .K_SHIFT(4), .FRAC_W(8), .HOLDOFF(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ch(ch5), .in_data(in_data),
    .thresh(thresh), .bl_clear(bl_clear), .out_valid(ov5), .out_ch(och5),
    .out_data(od5), .out_baseline(ob5), .out_hold(oh5));
  typedef struct {
    logic v; logic [1:0] ch; logic [13:0] d; logic clr;
    logic ev; int ed; int eb; logic eh; logic cd;
  } vec_t;
  vec_t tv[$];
  vec_t pend;
  function automatic vec_t mk(int ch, int d, logic clr, int ed, int eb, logic eh);
    vec_t t;
    t.v = 1; t.ch = 2'(ch); t.d = 14'(d); t.clr = clr; t.ev = 1; t.eb = eb; t.eh = eh; t.cd = 1;
`ifdef BLR_CLAMP_EN
    t.ed = ed < 0 ? 0 : ed;
`else
    t.ed = ed;
`endif
    return t;
  endfunction
  function automatic vec_t idle();
    vec_t t;
    t.v = 0; t.ch = 0; t.d = 0; t.clr = 0; t.ev = 0; t.ed = 0; t.eb = 0; t.eh = 0; t.cd = 0;
    return t;
  endfunction
  task automatic chk(input string n, input integer a, input integer e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic step(input vec_t t);
    in_valid = t.v; in_ch = t.ch; in_data = t.d; bl_clear = t.clr;
    v5 = t.v; ch5 = {1'b0, t.ch};
    @(posedge clk); #1;
    chk("out_valid", out_valid, pend.ev);
    if (pend.ev) begin
      chk("out_ch", out_ch, pend.ch);
      chk("out_hold", out_hold, pend.eh);
      if (pend.cd) begin
        chk("out_data", $signed(out_data), pend.ed);
        chk("out_baseline", out_baseline, pend.eb);
      end
    end
    pend = t;
  endtask
  task automatic chk_zero(input string n);
    chk({n, " out_valid"}, out_valid, 0);
    chk({n, " out_ch"}, out_ch, 0);
    chk({n, " out_data"}, out_data, 0);
    chk({n, " out_baseline"}, out_baseline, 0);
    chk({n, " out_hold"}, out_hold, 0);
    chk({n, " ov5"}, ov5, 0);
  endtask
  initial begin
    int last;
    vec_t t;
    // hold-off: three pulses, then 16 held samples before tracking resumes
    tv.push_back(mk(0, 1000, 1, 0, 1000, 0));
    repeat (3) tv.push_back(mk(0, 1500, 0, 500, 1000, 1));
    repeat (16) tv.push_back(mk(0, 1000, 0, 0, 1000, 1));
    tv.push_back(mk(0, 1000, 0, 0, 1000, 0));
    tv.push_back(idle());
    // interleaved channels and back-to-back ch2
    tv.push_back(mk(0, 100, 1, 0, 100, 0));
    tv.push_back(mk(1, 200, 0, 0, 200, 0));
    tv.push_back(mk(2, 300, 0, 0, 300, 0));
    tv.push_back(mk(3, 400, 0, 0, 400, 0));
    tv.push_back(mk(0, 100, 0, 0, 100, 0));
    tv.push_back(mk(2, 300, 0, 0, 300, 0));
    tv.push_back(mk(2, 460, 0, 160, 300, 1));
    tv.push_back(mk(3, 400, 0, 0, 400, 0));
    tv.push_back(mk(1, 260, 0, 60, 200, 0));
    // clear coincident with a sample, and clear reaching other channels
    tv.push_back(mk(1, 700, 1, 0, 700, 0));
    tv.push_back(mk(1, 700, 0, 0, 700, 0));
    tv.push_back(mk(2, 460, 0, 0, 460, 0));
    // negative residuals and threshold boundary
    tv.push_back(mk(0, 1000, 1, 0, 1000, 0));
    tv.push_back(mk(0, 900, 0, -100, 1000, 0));
    tv.push_back(mk(0, 950, 0, -43, 993, 0));
    tv.push_back(mk(0, 1091, 0, 100, 991, 0));
    tv.push_back(mk(0, 1098, 0, 101, 997, 1));
    // full scale
    tv.push_back(mk(3, 16383, 1, 0, 16383, 0));
    tv.push_back(mk(3, 16383, 0, 0, 16383, 0));
    tv.push_back(mk(3, 16383, 0, 0, 16383, 0));
    tv.push_back(mk(1, 16383, 0, 0, 16383, 0));
    tv.push_back(mk(1, 0, 0, -16383, 16383, 0));
    // step from 1000 to 1050
    tv.push_back(mk(0, 1000, 1, 0, 1000, 0));
    tv.push_back(mk(0, 1050, 0, 50, 1000, 0));
    tv.push_back(mk(0, 1050, 0, 47, 1003, 0));
    tv.push_back(mk(0, 1050, 0, 44, 1006, 0));
    pend = idle();
    rst_n = 0; in_valid = 1; in_ch = 0; in_data = 123; thresh = 100; bl_clear = 0; v5 = 1; ch5 = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_zero("reset");
    end
    rst_n = 1;
    foreach (tv[i]) step(tv[i]);
    last = 50;
    repeat (13) begin
      t = mk(0, 1050, 0, 0, 0, 0);
      t.cd = 0;
      step(t);
      chk("monotone", int'($signed(out_data) <= last && $signed(out_data) >= 0), 1);
      last = $signed(out_data);
    end
    step(idle());
    step(idle());
    in_valid = 0; v5 = 1; ch5 = 5; in_data = 777;
    @(posedge clk); #1;
    v5 = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("ignored ch ov5", ov5, 0);
      chk("ignored ch out_valid", out_valid, 0);
    end
    v5 = 1; ch5 = 2; in_data = 50;
    @(posedge clk); #1;
    v5 = 0;
    @(posedge clk); #1;
    chk("dut5 ov5", ov5, 1);
    chk("dut5 och5", och5, 2);
    pend = idle();
    step(mk(0, 500, 1, 0, 500, 0));
    rst_n = 0; in_valid = 1; in_data = 600;
    repeat (2) begin
      @(posedge clk); #1;
      chk_zero("midreset");
    end
    rst_n = 1;
    pend = idle();
    step(mk(0, 700, 0, 0, 700, 0));
    step(idle());
    step(idle());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
